// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU) with granted writeback
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic [4:0]       busy_rd,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_we,
    input  logic             wb_grant
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo, rem_q, dvs;
    logic             neg_q, neg_r, is_rem;

    logic             sgn, a_neg, b_neg, div_zero, ovf, special, last, take, accept;
    logic [WIDTH-1:0] a_abs, b_abs, spec_res, rem_n, quo_n, res;
    logic [WIDTH:0]   r_sh, diff;

    assign in_ready = state == IDLE;
    assign busy     = ~in_ready;
    assign busy_rd  = busy ? rd : 5'd0;
    assign rd_we    = state == DONE;
    assign accept   = in_valid & in_ready & ~kill;

    assign sgn      = ~op[0];
    assign a_neg    = sgn & rs1_data[WIDTH-1];
    assign b_neg    = sgn & rs2_data[WIDTH-1];
    assign a_abs    = a_neg ? -rs1_data : rs1_data;
    assign b_abs    = b_neg ? -rs2_data : rs2_data;
    assign div_zero = rs2_data == '0;
    assign ovf      = sgn & (rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) & (rs2_data == '1);
    assign special  = div_zero | ovf;
    assign spec_res = op[1] ? (div_zero ? rs1_data : '0) : (div_zero ? '1 : rs1_data);

    // Remainder stays below the divisor, so the W+1-bit trial difference decides each quotient bit.
    assign r_sh  = {rem_q, quo[WIDTH-1]};
    assign diff  = r_sh - {1'b0, dvs};
    assign take  = ~diff[WIDTH];
    assign rem_n = take ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign quo_n = {quo[WIDTH-2:0], take};
    assign res   = is_rem ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
    assign last  = cnt == CW'(WIDTH-1);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = special ? DONE : CALC;
            CALC:    if (last) state_n = DONE;
            DONE:    if (wb_grant) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            quo     <= '0;
            rem_q   <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_rem  <= 1'b0;
            rd      <= 5'd0;
            rd_data <= '0;
        end else if (accept) begin
            cnt     <= '0;
            quo     <= a_abs;
            rem_q   <= '0;
            dvs     <= b_abs;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            is_rem  <= op[1];
            rd      <= rd_in;
            if (special) rd_data <= spec_res;
        end else if (state == CALC && !kill) begin
            cnt   <= cnt + 1'b1;
            quo   <= quo_n;
            rem_q <= rem_n;
            if (last) rd_data <= res;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit against an arithmetic reference model
module tb_div_unit;
    logic        clk = 0, rst = 1, kill = 0, in_valid = 0, wb_grant = 0;
    logic [1:0]  op = 0;
    logic [31:0] rs1_data = 0, rs2_data = 0;
    logic [4:0]  rd_in = 0;
    logic        in_ready, busy, rd_we;
    logic [4:0]  busy_rd, rd;
    logic [31:0] rd_data;
    int errors = 0, checks = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .busy_rd(busy_rd), .rd(rd), .rd_data(rd_data), .rd_we(rd_we),
        .wb_grant(wb_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = '1; r = a;
        end else if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a; r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input int hold);
        int n;
        logic [31:0] exp;
        bit spc;
        exp = model(o, a, b);
        spc = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        @(negedge clk);
        chk("ready_before", 32'(in_ready), 32'd1);
        in_valid = 1; op = o; rs1_data = a; rs2_data = b; rd_in = t;
        @(negedge clk);
        in_valid = 0; rs1_data = $urandom; rs2_data = $urandom;
        n = 1;
        while (!rd_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), spc ? 32'd1 : 32'd33);
        chk("rd", 32'(rd), 32'(t));
        chk("rd_data", rd_data, exp);
        chk("busy_rd", 32'(busy_rd), 32'(t));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_we", 32'(rd_we), 32'd1);
            chk("hold_data", rd_data, exp);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        wb_grant = 1;
        @(negedge clk);
        wb_grant = 0;
        chk("we_after_grant", 32'(rd_we), 32'd0);
        chk("idle_after_grant", 32'(in_ready), 32'd1);
        chk("busy_rd_idle", 32'(busy_rd), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(rd_we), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_busy_rd", 32'(busy_rd), 32'd0);
        @(negedge clk);
        rst = 0;

        run(2'b01, 32'd100, 32'd7, 5'd5, 5);
        run(2'b10, -32'sd7, 32'd2, 5'd3, 0);
        run(2'b00, -32'sd7, 32'd2, 5'd4, 1);
        run(2'b00, 32'd7, -32'sd2, 5'd6, 0);
        run(2'b00, 32'd1234, 32'd0, 5'd7, 0);
        run(2'b11, 32'hDEAD_BEEF, 32'd0, 5'd8, 2);
        run(2'b10, -32'sd9, 32'd0, 5'd9, 0);
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        run(2'b11, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
        run(2'b00, 32'h8000_0000, 32'd1, 5'd13, 0);

        // kill during CALC with a competing request
        @(negedge clk);
        in_valid = 1; op = 2'b01; rs1_data = 32'd500; rs2_data = 32'd3; rd_in = 5'd17;
        @(negedge clk);
        in_valid = 0;
        repeat (10) @(negedge clk);
        chk("calc_busy_rd", 32'(busy_rd), 32'd17);
        kill = 1; in_valid = 1; rd_in = 5'd21;
        @(negedge clk);
        kill = 0; in_valid = 0;
        chk("kill_ready", 32'(in_ready), 32'd1);
        chk("kill_busy_rd", 32'(busy_rd), 32'd0);
        chk("kill_we", 32'(rd_we), 32'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd_we || busy) n++;
        end
        chk("kill_no_write", 32'(n), 32'd0);

        // kill in IDLE discards the same-cycle accept
        in_valid = 1; kill = 1; rs2_data = 32'd0;
        @(negedge clk);
        in_valid = 0; kill = 0;
        chk("kill_accept_ready", 32'(in_ready), 32'd1);
        chk("kill_accept_we", 32'(rd_we), 32'd0);

        // async reset mid-CALC
        in_valid = 1; op = 2'b00; rs1_data = 32'd77; rs2_data = 32'd5; rd_in = 5'd9;
        @(negedge clk);
        in_valid = 0;
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_busy_rd", 32'(busy_rd), 32'd0);
        chk("arst_rd", 32'(rd), 32'd0);
        chk("arst_data", rd_data, 32'd0);
        chk("arst_we", 32'(rd_we), 32'd0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            if ($urandom_range(0, 7) == 0) a = -$signed(32'($urandom_range(0, 1000)));
            run(2'($urandom), a, b, 5'($urandom), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
